// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter that owns the shared 2:1 data mux
// and forwards bursts from the granted producer to one valid/ready channel.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req0/1     in   producer requests
//   data0/1    in   producer data, valid while the matching req is high
//   last0/1    in   final beat of the producer's burst
//   gnt0/1     out  registered grant, one-hot or zero
//   sel        out  registered mux select (owner of the channel)
//   out_valid  out  downstream beat valid
//   out_data   out  downstream data, sel ? data1 : data0
//   out_ready  in   downstream accept
//   busy       out  high while a grant is held
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e          state_q, state_d;
    logic            sel_q,   sel_d;
    logic            prio_q,  prio_d;
    logic            gnt0_q,  gnt0_d;
    logic            gnt1_q,  gnt1_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            req_own;
    logic            last_own;
    logic            req_prio;
    logic            req_alt;
    logic            in_grant;
    logic            accept;

    // Requests seen from the owner's and the pointer's point of view.
    assign req_own  = sel_q  ? req1  : req0;
    assign last_own = sel_q  ? last1 : last0;
    assign req_prio = prio_q ? req1  : req0;
    assign req_alt  = prio_q ? req0  : req1;

    assign in_grant = (state_q == GRANT);

    // Valid follows the owner's request directly, so a withdrawn
    // request never presents a beat downstream.
    assign out_valid = in_grant & req_own;
    assign out_data  = sel_q ? data1 : data0;
    assign accept    = out_valid & out_ready;

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign sel  = sel_q;
    assign busy = in_grant;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_prio || req_alt) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                    sel_d   = req_prio ? prio_q : ~prio_q;
                    gnt0_d  = ~sel_d;
                    gnt1_d  = sel_d;
                end
            end
            GRANT: begin
                if (!req_own) begin
                    // Withdrawn: release without a transfer.
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    prio_d  = ~sel_q;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (last_own || (cnt_q == CNT_LAST)) begin
                        state_d = IDLE;
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                        prio_d  = ~sel_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       last0, last1;
    logic       gnt0, gnt1;
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int beats  = 0;
    int b0;

    rr_mux_arbiter #(
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .last0     (last0),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && out_valid && out_ready)
            beats <= beats + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_chk(input string tag, input logic g0,
                             input logic g1);
        #1;
        check({tag, ".gnt0"}, 32'(gnt0), 32'(g0));
        check({tag, ".gnt1"}, 32'(gnt1), 32'(g1));
        check({tag, ".busy"}, 32'(busy), 32'(g0 | g1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.gnt0", 32'(gnt0), 0);
        check("rst.gnt1", 32'(gnt1), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.vld",  32'(out_valid), 0);
        check("rst.sel",  32'(sel), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = 0; data1 = 0; out_ready = 0;
        #2;
        do_reset();

        // Single-beat burst from producer 0.
        req0 = 1; last0 = 1; data0 = 8'hA5; out_ready = 1;
        grant_chk("t1.pre", 0, 0);
        cyc();
        grant_chk("t1.g", 1, 0);
        check("t1.vld",  32'(out_valid), 1);
        check("t1.data", 32'(out_data), 32'hA5);
        b0 = beats;
        cyc();
        req0 = 0; last0 = 0;
        grant_chk("t1.rel", 0, 0);
        check("t1.vld0", 32'(out_valid), 0);
        check("t1.beats", 32'(beats - b0), 1);
        // Pointer moved to 1: both requesting, 1 wins.
        req0 = 1; req1 = 1; last0 = 1; last1 = 1;
        cyc();
        grant_chk("t1.prio", 0, 1);
        check("t1.sel", 32'(sel), 1);
        req0 = 0; req1 = 0;
        cyc();
        grant_chk("t1.drop", 0, 0);

        // Alternation with both requesting, single-beat bursts.
        do_reset();
        req0 = 1; req1 = 1; last0 = 1; last1 = 1;
        data0 = 8'h11; data1 = 8'h22; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            grant_chk($sformatf("t2.g%0d", k), k % 2 == 0, k % 2 == 1);
            check($sformatf("t2.sel%0d", k), 32'(sel), 32'(k % 2));
            check($sformatf("t2.d%0d", k), 32'(out_data),
                  (k % 2 == 0) ? 32'h11 : 32'h22);
            cyc();
            grant_chk($sformatf("t2.bub%0d", k), 0, 0);
            check($sformatf("t2.bsel%0d", k), 32'(sel), 32'(k % 2));
        end
        req0 = 0; req1 = 0; last0 = 0; last1 = 0;

        // MAX_BURST limit on producer 1 with last held low.
        req1 = 1; data1 = 8'h3C;
        cyc();
        grant_chk("t3.g", 0, 1);
        b0 = beats;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3.g%0d", i), 32'(gnt1), 1);
            check($sformatf("t3.v%0d", i), 32'(out_valid), 1);
            if (i == 3)
                check("t3.cnt", 32'(dut.cnt_q), 3);
            cyc();
        end
        grant_chk("t3.rel", 0, 0);
        check("t3.beats", 32'(beats - b0), 4);
        cyc();
        grant_chk("t3.regnt", 0, 1);
        req1 = 0;
        #1;
        check("t3.wvld", 32'(out_valid), 0);
        b0 = beats;
        cyc();
        grant_chk("t3.wrel", 0, 0);
        check("t3.wbeats", 32'(beats - b0), 0);

        // Back-pressure in a 3-beat burst on producer 0.
        req0 = 1; last0 = 0; data0 = 8'h30; out_ready = 1;
        cyc();
        grant_chk("t4.g", 1, 0);
        b0 = beats;
        cyc();
        out_ready = 0; data0 = 8'h31;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("t4.hg%0d", i), 32'(gnt0), 1);
            check($sformatf("t4.hv%0d", i), 32'(out_valid), 1);
        end
        check("t4.hdat", 32'(out_data), 32'h31);
        check("t4.hbeats", 32'(beats - b0), 1);
        out_ready = 1;
        cyc();
        data0 = 8'h32; last0 = 1;
        cyc();
        req0 = 0; last0 = 0;
        grant_chk("t4.rel", 0, 0);
        check("t4.beats", 32'(beats - b0), 3);

        // Producer 0 withdraws after 2 beats; waiting producer 1 follows.
        req0 = 1; data0 = 8'h40;
        cyc();
        grant_chk("t5.g", 1, 0);
        req1 = 1; last1 = 1; data1 = 8'h55;
        b0 = beats;
        cyc();
        cyc();
        check("t5.nopre", 32'(gnt1), 0);
        req0 = 0;
        #1;
        check("t5.vld0", 32'(out_valid), 0);
        cyc();
        grant_chk("t5.rel", 0, 0);
        check("t5.beats", 32'(beats - b0), 2);
        cyc();
        grant_chk("t5.g1", 0, 1);
        check("t5.d1", 32'(out_data), 32'h55);
        cyc();
        req1 = 0; last1 = 0;
        grant_chk("t5.rel1", 0, 0);

        // Asynchronous reset mid-burst of producer 1 with prio at 1.
        req0 = 1; last0 = 1;
        cyc();
        cyc();
        req0 = 0; last0 = 0;
        req1 = 1; last1 = 0;
        cyc();
        grant_chk("t6.g", 0, 1);
        check("t6.sel1", 32'(sel), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6.gnt1", 32'(gnt1), 0);
        check("t6.busy", 32'(busy), 0);
        check("t6.vld",  32'(out_valid), 0);
        check("t6.sel",  32'(sel), 0);
        req0 = 1;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        grant_chk("t6.first", 1, 0);
        req0 = 0; req1 = 0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
